// File: rtl/change_dispenser.sv
// Pays owed change out as nickels and dimes over a four-phase eject/ack hopper
// handshake, tracking coin inventory, short-change, overflow and hopper jams.
module change_dispenser #(
  parameter int CNT_W       = 6,
  parameter int NICKEL_INIT = 10,
  parameter int DIME_INIT   = 10,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vend,
  input  logic [2:0]       change,
  input  logic             coin_ack,
  input  logic             refill_nickel,
  input  logic             refill_dime,
  output logic             eject_nickel,
  output logic             eject_dime,
  output logic             busy,
  output logic             done,
  output logic             short_change,
  output logic             overflow,
  output logic             bad_code,
  output logic             jam,
  output logic [CNT_W-1:0] nickel_count,
  output logic [CNT_W-1:0] dime_count
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] NICKEL_RST = CNT_W'(NICKEL_INIT);
  localparam logic [CNT_W-1:0] DIME_RST   = CNT_W'(DIME_INIT);

  typedef enum logic [2:0] {
    IDLE, SELECT, EJECT_D, EJECT_N, RELEASE, DONE, FAULT
  } state_t;

  state_t           state, state_next;
  logic [2:0]       rem, rem_next;
  logic [2:0]       pend, pend_next;
  logic             pend_valid, pend_valid_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic             short_next, jam_next, bad_next, ovf_next;
  logic             take_nickel, take_dime;
  logic [CNT_W-1:0] nickel_next, dime_next;
  logic             vend_ok, vend_bad;

  assign vend_ok  = vend && (change != 3'd0) && (change <= 3'd5);
  assign vend_bad = vend && (change > 3'd5);

  always_comb begin
    state_next      = state;
    rem_next        = rem;
    pend_next       = pend;
    pend_valid_next = pend_valid;
    timer_next      = timer;
    short_next      = short_change;
    jam_next        = jam;
    bad_next        = vend_bad && (state != FAULT);
    ovf_next        = 1'b0;
    take_nickel     = 1'b0;
    take_dime       = 1'b0;

    // A request arriving mid-payout waits in the single-entry buffer
    if (vend_ok && (state inside {SELECT, EJECT_D, EJECT_N, RELEASE})) begin
      if (!pend_valid) begin
        pend_next       = change;
        pend_valid_next = 1'b1;
      end else begin
        ovf_next = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (vend_ok) begin
          rem_next   = change;
          short_next = 1'b0;
          state_next = SELECT;
        end
      end
      SELECT: begin
        timer_next = '0;
        if (rem == 3'd0) begin
          state_next = DONE;
        end else if ((rem >= 3'd2) && (dime_count != '0)) begin
          state_next = EJECT_D;
        end else if (nickel_count != '0) begin
          state_next = EJECT_N;
        end else begin
          short_next = 1'b1;
          state_next = DONE;
        end
      end
      EJECT_D, EJECT_N: begin
        if (coin_ack) begin
          if (state == EJECT_D) begin
            take_dime = 1'b1;
            rem_next  = rem - 3'd2;
          end else begin
            take_nickel = 1'b1;
            rem_next    = rem - 3'd1;
          end
          state_next = RELEASE;
        end else if (timer == TMR_LAST) begin
          jam_next   = 1'b1;
          state_next = FAULT;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      RELEASE: begin
        if (!coin_ack) state_next = SELECT;
      end
      // A vend landing in DONE is chained straight in rather than buffered
      DONE: begin
        if (pend_valid) begin
          rem_next   = pend;
          short_next = 1'b0;
          state_next = SELECT;
          if (vend_ok) pend_next = change;
          else pend_valid_next = 1'b0;
        end else if (vend_ok) begin
          rem_next   = change;
          short_next = 1'b0;
          state_next = SELECT;
        end else begin
          state_next = IDLE;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Refill and a same-coin payout in one cycle cancel; refills saturate
  always_comb begin
    nickel_next = nickel_count;
    dime_next   = dime_count;
    if (refill_nickel && !take_nickel) begin
      if (nickel_count != CNT_MAX) nickel_next = nickel_count + CNT_W'(1);
    end else if (take_nickel && !refill_nickel) begin
      nickel_next = nickel_count - CNT_W'(1);
    end
    if (refill_dime && !take_dime) begin
      if (dime_count != CNT_MAX) dime_next = dime_count + CNT_W'(1);
    end else if (take_dime && !refill_dime) begin
      dime_next = dime_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      rem          <= '0;
      pend         <= '0;
      pend_valid   <= 1'b0;
      timer        <= '0;
      eject_nickel <= 1'b0;
      eject_dime   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      short_change <= 1'b0;
      overflow     <= 1'b0;
      bad_code     <= 1'b0;
      jam          <= 1'b0;
      nickel_count <= NICKEL_RST;
      dime_count   <= DIME_RST;
    end else begin
      state        <= state_next;
      rem          <= rem_next;
      pend         <= pend_next;
      pend_valid   <= pend_valid_next;
      timer        <= timer_next;
      eject_nickel <= (state_next == EJECT_N);
      eject_dime   <= (state_next == EJECT_D);
      busy         <= (state_next != IDLE);
      done         <= (state_next == DONE);
      short_change <= short_next;
      overflow     <= ovf_next;
      bad_code     <= bad_next;
      jam          <= jam_next;
      nickel_count <= nickel_next;
      dime_count   <= dime_next;
    end
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Output-side counterpart to the coin-accepting vending FSM: consumes that FSM's vend/change outputs and pays the change out as physical coins.
- Drives a coin hopper one coin at a time over a four-phase eject/ack handshake.
- Tracks nickel and dime inventory, and flags short-change, overflow and hopper jams.

Parameters:
- CNT_W, 6, width of each inventory counter; saturates at 2^CNT_W-1.
- NICKEL_INIT, 10, nickel inventory after reset.
- DIME_INIT, 10, dime inventory after reset.
- ACK_TIMEOUT, 16, cycles in EJECT without coin_ack before jam (>=2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- vend  in  1  1-cycle pulse from the vending FSM: transaction complete.
- change  in  3  change owed, in nickel units (0=none, 1=5c, 2=10c, 3=15c, 4=20c, 5=25c); sampled only with vend.
- coin_ack  in  1  hopper acknowledge: coin released.
- refill_nickel  in  1  pulse: +1 nickel.
- refill_dime  in  1  pulse: +1 dime.
- eject_nickel  out  1  request: eject one nickel.
- eject_dime  out  1  request: eject one dime.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse: payout finished.
- short_change  out  1  payout ended with change still owed.
- overflow  out  1  1-cycle pulse: request dropped.
- bad_code  out  1  1-cycle pulse: vend arrived with change 6 or 7.
- jam  out  1  sticky hopper fault.
- nickel_count  out  CNT_W  current nickel inventory.
- dime_count  out  CNT_W  current dime inventory.

Behaviour:
- All outputs are registered.
- Reset values:
  - State is IDLE.
  - All 1-bit outputs are 0.
  - Counts equal NICKEL_INIT and DIME_INIT.
  - rem=0; pending buffer empty.
- Request acceptance:
  - In IDLE, vend with change 1..5 loads rem=change; next state is SELECT.
  - vend with change=0 is ignored.
  - vend with change 6/7 is ignored and pulses bad_code next cycle.
- Pending buffer (one entry):
  - vend with valid nonzero change while not IDLE is stored if the buffer is empty.
  - If the buffer is full, the request is dropped and overflow pulses.
- SELECT (greedy):
  - rem==0 -> DONE.
  - rem>=2 and dime_count>0 -> EJECT_D.
  - Else nickel_count>0 -> EJECT_N.
  - Else DONE with short_change=1.
- EJECT_D / EJECT_N:
  - The matching eject_* is high for the whole state; only one eject is ever high.
  - On coin_ack=1: decrement the inventory, rem -= 2 (dime) or 1 (nickel), drop eject, go to RELEASE.
  - The timer counts cycles in EJECT. On reaching ACK_TIMEOUT without ack: jam=1, eject low, go to FAULT.
- RELEASE: wait for coin_ack=0, then SELECT. No new eject is issued while ack is still high.
- DONE:
  - done=1 for one cycle.
  - If pending is valid: load rem from it, clear it, go to SELECT (busy stays 1).
  - Otherwise go to IDLE.
- short_change:
  - Set in SELECT as above.
  - Cleared when the next request is loaded into rem.
- FAULT:
  - Sticky until reset; ignores vend (no pending, no overflow); ejects low; busy=1.
- Refill:
  - A refill pulse adds 1, saturating.
  - Refill and decrement of the same coin in the same cycle give a net 0.
  - Refill is accepted in every state, including FAULT.
- Latency for 5c change with stock: vend at edge N gives SELECT at N+1, eject_nickel high at N+2.
- Reset mid-payout:
  - Aborts immediately; eject low next cycle; pending cleared.
  - Inventory returns to INIT values.

Test Plan:
- Full stock, vend with change=5, ack 2 cycles after each eject -> eject_dime, eject_dime, eject_nickel in that order; dime_count 10->8; nickel_count 10->9; one done pulse; short_change=0.
- DIME_INIT=0, vend with change=4 -> four eject_nickel handshakes; nickel_count=6; done pulse.
- Nickels=0, dimes=1, vend with change=3 -> one dime ejected, then done with short_change=1; the next vend with change=1 and a refill_nickel clears short_change.
- During a payout: a second vend (change=2) is buffered and a third (change=1) pulses overflow. After the first done, the second payout starts with no IDLE cycle and produces a second done.
- coin_ack held at 0 -> eject drops after 16 cycles; jam=1; later vend ignored. Reset -> jam=0, counts restored to 10/10.
- vend with change=7 -> bad_code pulse, no eject. refill_dime coincident with a dime ack -> dime_count unchanged.
